// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write master.
package i2c_pkg;

    // Frame-level FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StBit,
        StAck,
        StStop
    } i2c_state_e;

    // Position within one SCL period (four quarters).
    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quarter_e;

    // WM8731 device address with the write bit.
    localparam logic [7:0] ADDR_WM8731_W = 8'h34;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period divider: counts 0..CLK_DIV-1 while enabled, ticks on terminal count.
module i2c_quarter_tick #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == CntMax);

    // Next count: held at zero while idle so each frame starts on a full quarter.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_write_master.sv
// Write-only I2C master: NBYTES-byte frames, per-byte ACK check, retry on NACK.
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 125,
    parameter int unsigned NBYTES    = 3,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                start,
    input  logic [8*NBYTES-1:0] data,
    output logic                busy,
    output logic                done,
    output logic                ack_err,
    output logic                scl_o,
    output logic                sda_oe,
    input  logic                sda_i
);
    localparam int unsigned FrameW = 8 * NBYTES;
    localparam int unsigned ByteW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [ByteW-1:0] LastByte = ByteW'(NBYTES - 1);
    localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);

    i2c_state_e        state_q, state_d;
    quarter_e          phase_q, phase_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [ByteW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [2:0]        retry_q, retry_d;
    logic [FrameW-1:0] shift_q, shift_d;
    logic [FrameW-1:0] data_q, data_d;
    logic              nack_q, nack_d;
    logic              done_q, done_d;
    logic              ack_err_q, ack_err_d;
    logic              scl_q, scl_d;
    logic              sda_oe_q, sda_oe_d;
    logic              sda_meta_q, sda_sync_q;
    logic              tick;
    logic              scl_high_half;

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign scl_o   = scl_q;
    assign sda_oe  = sda_oe_q;

    i2c_quarter_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_quarter_tick (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .en_i  (busy),
        .tick_o(tick)
    );

    // State register, registered pin drivers and SDA resynchroniser.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= StIdle;
            phase_q    <= Q0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            retry_q    <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            nack_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            retry_q    <= retry_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            nack_q     <= nack_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
        end
    end

    // Next-state logic: everything advances on the last quarter of each phase.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        retry_d    = retry_q;
        shift_d    = shift_q;
        data_d     = data_q;
        nack_d     = nack_q;
        ack_err_d  = ack_err_q;
        done_d     = 1'b0;
        case (state_q)
            StIdle: begin
                // A start coinciding with the done pulse is deliberately dropped.
                if (start && !done_q) begin
                    state_d   = StStart;
                    phase_d   = Q0;
                    shift_d   = data;
                    data_d    = data;
                    retry_d   = '0;
                    nack_d    = 1'b0;
                    ack_err_d = 1'b0;
                end
            end
            default: begin
                if (tick) begin
                    phase_d = quarter_e'(phase_q + 2'd1);
                    if (phase_q == Q3) begin
                        case (state_q)
                            StStart: begin
                                state_d    = StBit;
                                bit_cnt_d  = '0;
                                byte_cnt_d = '0;
                            end
                            StBit: begin
                                shift_d   = {shift_q[FrameW-2:0], 1'b0};
                                bit_cnt_d = bit_cnt_q + 3'd1;
                                if (bit_cnt_q == 3'd7) begin
                                    state_d = StAck;
                                end
                            end
                            StAck: begin
                                if (sda_sync_q) begin
                                    nack_d  = 1'b1;
                                    state_d = StStop;
                                end else if (byte_cnt_q == LastByte) begin
                                    state_d = StStop;
                                end else begin
                                    byte_cnt_d = byte_cnt_q + ByteW'(1);
                                    state_d    = StBit;
                                end
                            end
                            StStop: begin
                                if (nack_q && (retry_q < MaxRetry)) begin
                                    retry_d = retry_q + 3'd1;
                                    shift_d = data_q;
                                    nack_d  = 1'b0;
                                    state_d = StStart;
                                end else begin
                                    done_d    = 1'b1;
                                    ack_err_d = nack_q;
                                    state_d   = StIdle;
                                end
                            end
                            default: state_d = StIdle;
                        endcase
                    end
                end
            end
        endcase
    end

    // Pin levels decoded from state and quarter; registered before driving the pins.
    always_comb begin
        scl_high_half = (phase_q == Q2) || (phase_q == Q3);
        scl_d         = 1'b1;
        sda_oe_d      = 1'b0;
        case (state_q)
            StStart: begin
                scl_d    = (phase_q == Q0) || (phase_q == Q1);
                sda_oe_d = (phase_q != Q0);
            end
            StBit: begin
                scl_d    = scl_high_half;
                sda_oe_d = ~shift_q[FrameW-1];
            end
            StAck: begin
                scl_d    = scl_high_half;
                sda_oe_d = 1'b0;
            end
            StStop: begin
                scl_d    = scl_high_half;
                sda_oe_d = (phase_q != Q3);
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_write_master.sv
// Randomised bench for i2c_write_master with a bus-level slave/decoder model.
module tb_i2c_write_master;
    import i2c_pkg::*;

    localparam int unsigned CDIV_A = 16;
    localparam int unsigned NB_A   = 3;
    localparam int unsigned MR     = 2;
    localparam int unsigned CDIV_B = 2;
    localparam int unsigned NB_B   = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [23:0] data_a = '0;
    logic [7:0]  data_b = '0;
    logic        busy_a, done_a, ack_err_a, scl_a, oe_a, sda_in_a;
    logic        busy_b, done_b, ack_err_b, scl_b, oe_b, sda_in_b;
    logic        sel = 1'b0;
    logic        pull = 1'b0;
    logic        mon_scl, mon_sda, t_busy, t_done, t_err, t_oe;

    assign sda_in_a = ~(oe_a | (pull & ~sel));
    assign sda_in_b = ~(oe_b | (pull & sel));
    assign mon_scl  = sel ? scl_b : scl_a;
    assign mon_sda  = sel ? sda_in_b : sda_in_a;
    assign t_busy   = sel ? busy_b : busy_a;
    assign t_done   = sel ? done_b : done_a;
    assign t_err    = sel ? ack_err_b : ack_err_a;
    assign t_oe     = sel ? oe_b : oe_a;

    i2c_write_master #(.CLK_DIV(CDIV_A), .NBYTES(NB_A), .MAX_RETRY(MR)) u_dut_a (
        .sys_clk(clk), .sys_rst(rst), .start(start_a), .data(data_a), .busy(busy_a),
        .done(done_a), .ack_err(ack_err_a), .scl_o(scl_a), .sda_oe(oe_a), .sda_i(sda_in_a)
    );

    i2c_write_master #(.CLK_DIV(CDIV_B), .NBYTES(NB_B), .MAX_RETRY(MR)) u_dut_b (
        .sys_clk(clk), .sys_rst(rst), .start(start_b), .data(data_b), .busy(busy_b),
        .done(done_b), .ack_err(ack_err_b), .scl_o(scl_b), .sda_oe(oe_b), .sda_i(sda_in_b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus monitor and slave: decodes START/STOP/bits, acks per plan, checks SCL period.
    int         plan [3] = '{3, 3, 3};
    int         att_base = 0;
    int         per_exp = 4 * CDIV_A;
    int         starts = 0, stops = 0, pulses = 0, per_err = 0, sda_err = 0;
    logic [7:0] got_q[$];

    initial begin
        logic       p_scl, p_sda, in_frame, rise_valid, rel_pend;
        logic [7:0] sh;
        int         bitpos, byte_idx, last_rise, att;
        p_scl = 1'b1; p_sda = 1'b1; in_frame = 1'b0; rise_valid = 1'b0; rel_pend = 1'b0;
        sh = '0; bitpos = 0; byte_idx = 0; last_rise = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0; rise_valid = 1'b0; rel_pend = 1'b0;
                bitpos = 0; byte_idx = 0; pull = 1'b0;
            end else if (p_scl && mon_scl && p_sda && !mon_sda) begin
                if (bitpos != 0) sda_err++;
                starts++;
                in_frame = 1'b1; bitpos = 0; byte_idx = 0; rise_valid = 1'b0;
            end else if (p_scl && mon_scl && !p_sda && mon_sda) begin
                // The SCL rise just before STOP was provisionally taken as a data bit.
                if (bitpos == 1) begin
                    pulses--;
                    bitpos = 0;
                end else if (bitpos != 0) begin
                    sda_err++;
                end
                if (!in_frame) sda_err++;
                stops++;
                in_frame = 1'b0; rise_valid = 1'b0;
            end else if (!p_scl && mon_scl && in_frame) begin
                if (rise_valid && (cyc - last_rise) != per_exp) per_err++;
                last_rise = cyc; rise_valid = 1'b1; pulses++;
                if (bitpos < 8) begin
                    sh = {sh[6:0], mon_sda};
                    bitpos++;
                    if (bitpos == 8) got_q.push_back(sh);
                end else begin
                    bitpos = 0; rel_pend = 1'b1; byte_idx++;
                end
            end else if (p_scl && !mon_scl && in_frame) begin
                if (bitpos == 8) begin
                    att = starts - att_base - 1;
                    pull = !(att >= 0 && att < 3 && plan[att] == byte_idx);
                end else if (rel_pend) begin
                    pull = 1'b0; rel_pend = 1'b0;
                end
            end
            p_scl = mon_scl;
            p_sda = mon_sda;
        end
    end

    function automatic logic [7:0] byte_of(input logic [23:0] d, input int nb, input int i);
        return d[8*(nb-1-i) +: 8];
    endfunction

    task automatic set_start(input logic b, input logic v, input logic [23:0] d);
        if (b) begin
            start_b = v; data_b = d[7:0];
        end else begin
            start_a = v; data_a = d;
        end
    endtask

    // One frame: plan[a] = index of the byte NACKed on attempt a (>= nbytes: all ACKed).
    task automatic run_frame(input logic b, input logic [23:0] d, input int p0, input int p1,
                             input int p2, input logic poke_mid, input logic poke_done);
        int nb, cd, exp_cycles, attempts, t0, k, bound, s0, e0, pu0, pe0, se0, g0, n_got;
        logic exp_err, seen;
        logic [7:0] exp_bytes[$];
        nb = b ? NB_B : NB_A;
        cd = b ? CDIV_B : CDIV_A;
        exp_cycles = 0; attempts = 0; exp_err = 1'b1;
        plan[0] = p0; plan[1] = p1; plan[2] = p2;
        for (int a = 0; a <= MR; a++) begin
            attempts++;
            if (plan[a] >= nb) begin
                exp_cycles += (8 + 36 * nb) * cd;
                exp_err = 1'b0;
                for (int i = 0; i < nb; i++) exp_bytes.push_back(byte_of(d, nb, i));
                break;
            end
            exp_cycles += (8 + 36 * (plan[a] + 1)) * cd;
            for (int i = 0; i <= plan[a]; i++) exp_bytes.push_back(byte_of(d, nb, i));
        end

        @(negedge clk);
        sel = b; per_exp = 4 * cd; att_base = starts;
        s0 = starts; e0 = stops; pu0 = pulses; pe0 = per_err; se0 = sda_err; g0 = got_q.size();
        set_start(b, 1'b1, d);
        t0 = cyc;
        @(negedge clk);
        set_start(b, 1'b0, d);
        check_eq("busy_after_start", t_busy, 1);
        check_eq("ack_err_cleared", t_err, 0);

        seen = 1'b0; k = 0; bound = exp_cycles + 200;
        while (!seen && k < bound) begin
            @(negedge clk);
            k++;
            if (poke_mid && k == exp_cycles / 2) set_start(b, 1'b1, ~d);
            if (poke_mid && k == exp_cycles / 2 + 1) set_start(b, 1'b0, d);
            if (t_done) begin
                seen = 1'b1;
                check_eq("done_time", cyc - t0, exp_cycles + 1);
                check_eq("ack_err", t_err, exp_err);
                check_eq("busy_at_done", t_busy, 0);
                check_eq("sda_oe_at_done", t_oe, 0);
                if (poke_done) set_start(b, 1'b1, ~d);
            end
        end
        if (!seen) check_eq("done_timeout", 0, 1);
        @(negedge clk);
        set_start(b, 1'b0, d);
        check_eq("no_restart", t_busy, 0);
        repeat (16 * cd + 4) @(negedge clk);
        check_eq("idle_after", t_busy, 0);
        check_eq("ack_err_hold", t_err, exp_err);
        check_eq("attempts_start", starts - s0, attempts);
        check_eq("attempts_stop", stops - e0, attempts);
        check_eq("scl_pulses", pulses - pu0, 9 * exp_bytes.size());
        check_eq("scl_period", per_err - pe0, 0);
        check_eq("sda_stable", sda_err - se0, 0);
        n_got = got_q.size() - g0;
        check_eq("byte_count", n_got, exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < n_got; i++) begin
            check_eq($sformatf("byte%0d", i), got_q[g0 + i], exp_bytes[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: still running at %0t, required done earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_ack_err", ack_err_a, 0);
        check_eq("rst_scl", scl_a, 1);
        check_eq("rst_sda_oe", oe_a, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(1'b0, 24'hAA3CC3, 3, 3, 3, 1'b0, 1'b0);
        run_frame(1'b0, 24'h5A1234, 1, 3, 3, 1'b0, 1'b0);
        run_frame(1'b0, 24'h34F00F, 0, 0, 0, 1'b0, 1'b0);
        run_frame(1'b0, 24'hC3A55A, 3, 3, 3, 1'b1, 1'b1);

        // Reset in the middle of bit 5 of byte 2.
        @(negedge clk);
        sel = 1'b0;
        set_start(1'b0, 1'b1, 24'h123456);
        t0 = cyc;
        @(negedge clk);
        set_start(1'b0, 1'b0, 24'h123456);
        while (cyc < t0 + 96 * CDIV_A + 2) @(negedge clk);
        check_eq("pre_rst_busy", busy_a, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_scl", scl_a, 1);
        check_eq("midrst_sda_oe", oe_a, 0);
        check_eq("midrst_busy", busy_a, 0);
        check_eq("midrst_done", done_a, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        run_frame(1'b0, 24'h9E37C1, 3, 3, 3, 1'b0, 1'b0);

        run_frame(1'b1, {16'h0, ADDR_WM8731_W}, 1, 1, 1, 1'b0, 1'b0);

        for (int r = 0; r < 5; r++) begin
            run_frame(1'b0, 24'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_write_master.md
# i2c_write_master

Parametrised I2C write-only master for codec register configuration. Generalises the fixed 24-bit WM8731 control write (device address + 16-bit register word) to NBYTES-byte frames, a programmable SCL rate, per-byte acknowledge checking and automatic retry on NACK. Sits between the codec configuration sequencer and the board I2C pins, and is exercised by the I2C functional model in the codec testbench.

## Interface
- CLK_DIV, 125: sys_clk cycles per SCL quarter-period (50 MHz / (4*125) = 100 kHz SCL); legal range 2..4095.
- NBYTES, 3: bytes per frame, first byte = device address + R/W bit; legal range 1..8.
- MAX_RETRY, 2: frame re-attempts after a NACK before giving up; legal range 0..7.
- sys_clk  in  1  system clock (50 MHz).
- sys_rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request; ignored while busy=1.
- data  in  8*NBYTES  frame payload, MSB first; byte 0 = data[8*NBYTES-1 -: 8]; captured when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the frame ends (success or final failure).
- ack_err  out  1  valid with done; 1 = last attempt NACKed; holds until the next accepted start.
- scl_o  out  1  SCL, driven push-pull.
- sda_oe  out  1  1 = pull SDA low; 0 = release (external pull-up).
- sda_i  in  1  SDA pin level, resynchronised internally with 2 flops.

## Operation
- Reset values: busy=0, done=0, ack_err=0, scl_o=1, sda_oe=0; FSM in IDLE; retry counter = 0.
- The quarter tick is generated by a counter 0..CLK_DIV-1 that runs only while busy; tick fires on terminal count.
- States: IDLE -> START -> BIT -> ACK -> (BIT | STOP) -> (IDLE | START on retry).
- IDLE: on start, latch data into the shift register, clear ack_err and the retry count, go to START.
- START (4 quarters): q0 SDA released, SCL high; q1 SDA low; q2 SCL low; q3 hold.
- BIT (4 quarters per bit, 8 bits per byte): q0 SCL low and SDA = current MSB (sda_oe = ~bit); q1 hold; q2 SCL high; q3 hold, then shift.
- ACK (4 quarters): SDA released; SCL high in q2 and q3; synchronised sda_i sampled at the q3 tick. Low = ACK: next byte, or STOP after byte NBYTES-1. High = NACK: set a nack flag and go directly to STOP.
- STOP (4 quarters): q0 SCL low, SDA low; q1 hold; q2 SCL high; q3 SDA released.
- After STOP:
  - If nack and retry count < MAX_RETRY, increment the count, reload the latched data, and return to START.
  - Otherwise pulse done, set ack_err = nack, and go to IDLE.
- start while busy is dropped without any effect. A start in the same cycle as done is also ignored.
- Reset mid-frame forces all outputs to their reset values immediately, which releases the bus. No STOP is generated.

## Timing
- Start is accepted in cycle T; busy=1 from T+1.
- A successful frame takes Q = 8 + 36*NBYTES quarters. done is high in cycle T + Q*CLK_DIV + 1, and busy drops in the same cycle.
- Each failed attempt adds (8 + 36*k)*CLK_DIV cycles, where k = number of bytes sent up to and including the NACKed byte.
- SCL high time = 2*CLK_DIV cycles; low time = 2*CLK_DIV cycles.
- SDA changes only while SCL is low, except in START and STOP.
- sda_i sample point lies 2 sys_clk cycles of synchroniser delay plus at least CLK_DIV-2 cycles after the SCL rising edge.

## Structure
- Package i2c_pkg holds:
  - the state enum (IDLE, START, BIT, ACK, STOP);
  - the quarter-phase type;
  - constant ADDR_WM8731_W = 8'h34.
- Sub-module i2c_quarter_tick: the CLK_DIV divider, with enable input and tick output.
- Shift register, bit counter (0..7), byte counter (0..NBYTES-1) and retry counter live in the top FSM.

## Test plan
- NBYTES=3, CLK_DIV=125, data=24'hAA3CC3, model ACKs all bytes:
  - model decodes 10101010_00111100_11000011 and sees 27 SCL pulses with a 500-cycle period;
  - done at T+14501; ack_err=0.
- Model NACKs byte 1, then ACKs all bytes on the retry:
  - two START/STOP pairs observed;
  - done at T+(8+72)*125 + 14500 + 1; ack_err=0.
- MAX_RETRY=2, model NACKs the address byte every time:
  - three attempts observed;
  - done with ack_err=1; busy=0 afterwards; sda_oe=0.
- start pulsed again mid-frame and again in the done cycle:
  - no second frame is started, and the first frame is unaffected.
- sys_rst asserted during bit 5 of byte 2:
  - in the same cycle scl_o=1, sda_oe=0, busy=0, done=0;
  - a new start after release produces a clean full frame.
- NBYTES=1, CLK_DIV=2, data=8'h34:
  - done at T+(8+36)*2+1 = T+89; the SDA stable-while-SCL-high assertion holds throughout.
